// File: rtl/tiny_alu_pkg.sv
// Shared types and constants for the tiny ALU bus: opcode encoding,
// command-master FSM states and the default completion timeout.
package tiny_alu_pkg;

    typedef enum logic [2:0] {
        NOP = 3'b000,
        ADD = 3'b001,
        AND = 3'b010,
        XOR = 3'b011,
        MUL = 3'b100
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } master_state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/tiny_alu_cmd_master.sv
// Initiator for the tiny ALU bus: takes a command, holds start until done or
// timeout, and returns the captured result on a valid/ready response channel.
module tiny_alu_cmd_master
    import tiny_alu_pkg::*;
#(
    parameter int INPUT_DATA_BITS = 8,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
    parameter int COUNT_BITS      = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [2:0]                   cmd_opcode_i,
    input  logic [INPUT_DATA_BITS-1:0]   cmd_a_i,
    input  logic [INPUT_DATA_BITS-1:0]   cmd_b_i,
    output logic                         start_o,
    output logic [2:0]                   opcode_o,
    output logic [INPUT_DATA_BITS-1:0]   a_o,
    output logic [INPUT_DATA_BITS-1:0]   b_o,
    input  logic                         done_i,
    input  logic [2*INPUT_DATA_BITS-1:0] result_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [2*INPUT_DATA_BITS-1:0] rsp_result_o,
    output logic [2:0]                   rsp_opcode_o,
    output logic                         rsp_error_o,
    output logic [COUNT_BITS-1:0]        op_count_o,
    output logic                         busy_o
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    master_state_e                r_state;
    logic                         r_run;
    logic [7:0]                   r_tmo;
    logic                         r_start;
    logic [2:0]                   r_opcode;
    logic [INPUT_DATA_BITS-1:0]   r_a;
    logic [INPUT_DATA_BITS-1:0]   r_b;
    logic                         r_rsp_valid;
    logic [2*INPUT_DATA_BITS-1:0] r_rsp_result;
    logic [2:0]                   r_rsp_opcode;
    logic                         r_rsp_error;
    logic [COUNT_BITS-1:0]        r_op_count;
    logic                         w_cmd_ready;

    // r_run keeps cmd_ready low while in reset even though the state reads IDLE.
    assign w_cmd_ready = r_run && (r_state == IDLE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= IDLE;
            r_run        <= 1'b0;
            r_tmo        <= 8'd0;
            r_start      <= 1'b0;
            r_opcode     <= 3'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_opcode <= 3'd0;
            r_rsp_error  <= 1'b0;
            r_op_count   <= '0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (cmd_valid_i && w_cmd_ready) begin
                        r_opcode <= cmd_opcode_i;
                        r_a      <= cmd_a_i;
                        r_b      <= cmd_b_i;
                        r_start  <= 1'b1;
                        r_tmo    <= 8'd0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    // done takes priority over a timeout expiring in the same cycle
                    if (done_i) begin
                        r_rsp_result <= result_i;
                        r_rsp_opcode <= r_opcode;
                        r_rsp_error  <= 1'b0;
                        r_start      <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= RESP;
                    end else if (r_tmo == TMO_LAST) begin
                        r_rsp_result <= '0;
                        r_rsp_opcode <= r_opcode;
                        r_rsp_error  <= 1'b1;
                        r_start      <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        if (!r_rsp_error) begin
                            r_op_count <= r_op_count + 1'b1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o  = w_cmd_ready;
    assign busy_o       = (r_state != IDLE);
    assign start_o      = r_start;
    assign opcode_o     = r_opcode;
    assign a_o          = r_a;
    assign b_o          = r_b;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_result_o = r_rsp_result;
    assign rsp_opcode_o = r_rsp_opcode;
    assign rsp_error_o  = r_rsp_error;
    assign op_count_o   = r_op_count;

endmodule

// File: tb/tb_tiny_alu_cmd_master.sv
// Bench for tiny_alu_cmd_master driving a behavioural tiny ALU; directed test
// plan steps followed by randomized commands checked against a reference model.
module tb_tiny_alu_cmd_master;
    import tiny_alu_pkg::*;

    localparam int W   = 8;
    localparam int TMO = 16;

    logic          clk_i = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [2:0]    cmd_opcode_i = 3'd0;
    logic [W-1:0]  cmd_a_i = '0;
    logic [W-1:0]  cmd_b_i = '0;
    logic          start_o;
    logic [2:0]    opcode_o;
    logic [W-1:0]  a_o;
    logic [W-1:0]  b_o;
    logic          done_i;
    logic [2*W-1:0] result_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [2*W-1:0] rsp_result_o;
    logic [2:0]    rsp_opcode_o;
    logic          rsp_error_o;
    logic [15:0]   op_count_o;
    logic          busy_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int model_count = 0;
    int last_start_cyc = 0;

    always #5 clk_i = ~clk_i;
    always_ff @(posedge clk_i) cyc <= cyc + 1;

    tiny_alu_cmd_master #(.INPUT_DATA_BITS(W), .TIMEOUT_CYCLES(TMO), .COUNT_BITS(16)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_opcode_i(cmd_opcode_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
        .start_o(start_o), .opcode_o(opcode_o), .a_o(a_o), .b_o(b_o),
        .done_i(done_i), .result_i(result_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_opcode_o(rsp_opcode_o),
        .rsp_error_o(rsp_error_o), .op_count_o(op_count_o), .busy_o(busy_o)
    );

    // Behavioural ALU: done and result registered one cycle after start; unknown opcodes never finish.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            done_i   <= 1'b0;
            result_i <= '0;
        end else begin
            done_i <= start_o && (opcode_o <= 3'd4);
            case (opcode_o)
                3'd1:    result_i <= {8'd0, a_o} + {8'd0, b_o};
                3'd2:    result_i <= {8'd0, a_o & b_o};
                3'd3:    result_i <= {8'd0, a_o ^ b_o};
                3'd4:    result_i <= a_o * b_o;
                default: result_i <= '0;
            endcase
        end
    end

    function automatic logic [15:0] ref_result(input logic [2:0] opc, input logic [7:0] a, input logic [7:0] b);
        int ia = int'(a);
        int ib = int'(b);
        case (opc)
            ADD:     return 16'(ia + ib);
            AND:     return 16'(a & b);
            XOR:     return 16'(a ^ b);
            MUL:     return 16'(ia * ib);
            default: return 16'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the response handshake.
    task automatic run_op(input logic [2:0] opc, input logic [7:0] a, input logic [7:0] b, input int hold);
        int n;
        int starts;
        logic exp_err;
        logic [15:0] exp_res;
        exp_err = (opc > 3'd4);
        exp_res = exp_err ? 16'd0 : ref_result(opc, a, b);
        cmd_valid_i = 1'b1; cmd_opcode_i = opc; cmd_a_i = a; cmd_b_i = b;
        rsp_ready_i = (hold == 0);
        n = 0;
        while (!cmd_ready_o && n < 20) begin @(negedge clk_i); n++; end
        check("cmd_ready_before_accept", 32'(cmd_ready_o), 32'd1);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        last_start_cyc = cyc;
        check("start_after_accept", 32'(start_o), 32'd1);
        check("opcode_o", 32'(opcode_o), 32'(opc));
        check("operands_o", {16'd0, a_o, b_o}, {16'd0, a, b});
        check("cmd_ready_busy", 32'(cmd_ready_o), 32'd0);
        starts = 0; n = 1;
        while (!rsp_valid_o && n < 300) begin
            if (start_o) starts++;
            @(negedge clk_i); n++;
        end
        check("rsp_latency", 32'(n), exp_err ? 32'(TMO + 1) : 32'd3);
        check("start_high_cycles", 32'(starts), exp_err ? 32'(TMO) : 32'd2);
        check("rsp_result", 32'(rsp_result_o), 32'(exp_res));
        check("rsp_opcode", 32'(rsp_opcode_o), 32'(opc));
        check("rsp_error", 32'(rsp_error_o), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(rsp_valid_o), 32'd1);
            check("hold_result", 32'(rsp_result_o), 32'(exp_res));
            check("hold_cmd_ready", 32'(cmd_ready_o), 32'd0);
            check("hold_start", 32'(start_o), 32'd0);
            @(negedge clk_i);
        end
        rsp_ready_i = 1'b1;
        check("valid_at_handshake", 32'(rsp_valid_o), 32'd1);
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        if (!exp_err) model_count++;
        check("valid_after_handshake", 32'(rsp_valid_o), 32'd0);
        check("busy_after_handshake", 32'(busy_o), 32'd0);
        check("op_count", 32'(op_count_o), 32'(model_count));
        $display("op opc=%0d a=%02h b=%02h hold=%0d result=%04h err=%0d count=%0d",
                 opc, a, b, hold, rsp_result_o, rsp_error_o, op_count_o);
    endtask

    initial begin
        int s1;
        logic [2:0] ro;
        // Reset state
        repeat (3) @(negedge clk_i);
        check("reset_cmd_ready", 32'(cmd_ready_o), 32'd0);
        check("reset_outputs", {26'd0, start_o, rsp_valid_o, rsp_error_o, busy_o, 2'b00}, 32'd0);
        check("reset_count", 32'(op_count_o), 32'd0);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check("ready_after_release", 32'(cmd_ready_o), 32'd1);

        // ADD carry into upper byte
        run_op(ADD, 8'hFF, 8'h01, 0);

        // MUL then XOR back to back
        run_op(MUL, 8'hFF, 8'hFF, 0);
        s1 = last_start_cyc;
        run_op(XOR, 8'hAA, 8'h55, 0);
        check("b2b_start_gap", 32'(last_start_cyc - s1), 32'd4);

        // Response back-pressure
        run_op(AND, 8'hF0, 8'h3C, 5);

        // Unknown opcode times out
        run_op(3'b101, 8'h11, 8'h22, 0);

        // Reset in the middle of a MUL
        cmd_valid_i = 1'b1; cmd_opcode_i = MUL; cmd_a_i = 8'h12; cmd_b_i = 8'h34; rsp_ready_i = 1'b1;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        check("mul_start", 32'(start_o), 32'd1);
        @(negedge clk_i);
        #2 reset_n_i = 1'b0;
        #1;
        check("async_start_drop", 32'(start_o), 32'd0);
        check("async_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("async_count", 32'(op_count_o), 32'd0);
        model_count = 0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        rsp_ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            check("no_rsp_after_reset", 32'(rsp_valid_o), 32'd0);
        end
        run_op(ADD, 8'h03, 8'h04, 0);

        // NOP, then stale done must not make a second response
        run_op(NOP, 8'h5A, 8'hA5, 0);
        repeat (3) begin
            check("no_stale_rsp", 32'(rsp_valid_o), 32'd0);
            @(negedge clk_i);
        end
        check("count_after_nop", 32'(op_count_o), 32'(model_count));

        // Randomized commands
        for (int i = 0; i < 24; i++) begin
            ro = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            run_op(ro, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

endmodule
